cgra_config_sequencer: RTL and testbench

- Sequences configuration and execution of the CGRA `top` instance.
- On `start`, it does three things in order:
  - pulses the CGRA reset;
  - streams (address, data) configuration pairs from a word-addressed config memory onto the CGRA `config_addr_in`/`config_data_in` bus;
  - runs the array for a programmable number of cycles, then flags done.
- Replaces the hand-driven config/cycle-count logic in full-system benches. It is also the synthesizable loader for silicon bring-up.

---
 rtl/cgra_config_sequencer_pkg.sv | 20 ++
 rtl/cgra_config_sequencer_if.sv | 33 +++
 rtl/cgra_config_sequencer_cfg_hold_counter.sv | 26 ++
 rtl/cgra_config_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_cgra_config_sequencer.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/cgra_config_sequencer_pkg.sv
// Shared types and constants for the CGRA configuration sequencer.
// Holds the FSM state encoding, the table terminator word and the bus/counter widths.
package cgra_cfg_pkg;

    localparam int CFG_W = 32;
    localparam int RUN_W = 64;
    localparam logic [CFG_W-1:0] SENTINEL = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CRST,
        ST_FETCH_A,
        ST_FETCH_D,
        ST_LOAD,
        ST_HOLD,
        ST_RUN,
        ST_DONE
    } state_e;

endpackage

// File: rtl/cgra_config_sequencer_if.sv
// Config-memory read port plus the CGRA reset/config bus driven by the sequencer.
// master = sequencer side, slave = memory / CGRA side.
interface cgra_config_sequencer_if #(
    parameter int MEM_AW = 10
) ();
    logic                           mem_rd_en;
    logic [MEM_AW-1:0]              mem_rd_addr;
    logic [cgra_cfg_pkg::CFG_W-1:0] mem_rd_data;
    logic                           cgra_reset_out;
    logic [cgra_cfg_pkg::CFG_W-1:0] config_addr_out;
    logic [cgra_cfg_pkg::CFG_W-1:0] config_data_out;
    logic                           config_strobe;

    modport master (
        output mem_rd_en,
        output mem_rd_addr,
        input  mem_rd_data,
        output cgra_reset_out,
        output config_addr_out,
        output config_data_out,
        output config_strobe
    );

    modport slave (
        input  mem_rd_en,
        input  mem_rd_addr,
        output mem_rd_data,
        input  cgra_reset_out,
        input  config_addr_out,
        input  config_data_out,
        input  config_strobe
    );
endinterface

// File: rtl/cgra_config_sequencer_cfg_hold_counter.sv
// Load/decrement counter; o_last is high during the final cycle of a loaded interval.
// Shared by the CGRA reset pulse and the per-pair bus hold.
module cfg_hold_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_last
);
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_last = (r_cnt == CNT_W'(1));
endmodule

// File: rtl/cgra_config_sequencer.sv
// Pulses the CGRA reset, streams (address, data) pairs from the config table
// onto the CGRA config bus, then runs the array for run_cycles and flags done.
module cgra_config_sequencer
    import cgra_cfg_pkg::*;
#(
    parameter int               MEM_AW     = 10,
    parameter int               CFG_HOLD   = 2,
    parameter int               RST_CYCLES = 4,
    parameter logic [CFG_W-1:0] SENTINEL   = cgra_cfg_pkg::SENTINEL
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    input  logic                   start,
    input  logic                   abort,
    input  logic [RUN_W-1:0]       run_cycles,
    cgra_config_sequencer_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   error,
    output logic [MEM_AW-1:0]      entries_loaded
);
    localparam int IDX_W    = MEM_AW - 1;
    localparam int HOLD_MAX = (CFG_HOLD > RST_CYCLES) ? CFG_HOLD : RST_CYCLES;
    localparam int CNT_W    = $clog2(HOLD_MAX + 1);

    state_e             r_state, w_state_next;
    logic [IDX_W-1:0]   r_idx, w_idx_next;
    logic [CFG_W-1:0]   r_addr_q;
    logic [RUN_W-1:0]   r_run_cycles, r_run_cnt;

    logic               r_mem_rd_en, w_mem_rd_en;
    logic [MEM_AW-1:0]  r_mem_rd_addr, w_mem_rd_addr;
    logic               r_cgra_rst, w_cgra_rst;
    logic [CFG_W-1:0]   r_cfg_addr, w_cfg_addr;
    logic [CFG_W-1:0]   r_cfg_data, w_cfg_data;
    logic               r_strobe, w_strobe;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic               r_error, w_error;
    logic [MEM_AW-1:0]  r_entries, w_entries;

    logic               w_accept, w_sentinel, w_last_slot, w_run_end;
    logic               w_hold_last, w_hold_done, w_hold_load, w_hold_dec;
    logic [CNT_W-1:0]   w_hold_val;

    assign w_accept    = start && !abort && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_sentinel  = (bus.mem_rd_data == SENTINEL);
    assign w_last_slot = &r_idx;
    // run_cycles == 0 still spends one cycle in RUN.
    assign w_run_end   = (r_run_cycles == '0) || (r_run_cnt == r_run_cycles - RUN_W'(1));
    assign w_hold_done = (r_state == ST_HOLD) && w_hold_last && !abort;

    // One counter times both intervals: reloaded on every entry into CRST or HOLD.
    assign w_hold_load = ((w_state_next == ST_CRST) && (r_state != ST_CRST)) ||
                         ((w_state_next == ST_HOLD) && (r_state != ST_HOLD));
    assign w_hold_val  = (w_state_next == ST_CRST) ? CNT_W'(RST_CYCLES) : CNT_W'(CFG_HOLD);
    assign w_hold_dec  = (r_state == ST_CRST) || (r_state == ST_HOLD);

    cfg_hold_counter #(
        .CNT_W (CNT_W)
    ) u_hold_counter (
        .clk        (clk_in),
        .srst       (reset_in),
        .i_load     (w_hold_load),
        .i_load_val (w_hold_val),
        .i_dec      (w_hold_dec),
        .o_last     (w_hold_last)
    );

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE: if (w_accept) w_state_next = ST_CRST;
            ST_CRST:          if (w_hold_last) w_state_next = ST_FETCH_A;
            ST_FETCH_A:       w_state_next = ST_FETCH_D;
            ST_FETCH_D:       w_state_next = w_sentinel ? ST_RUN : ST_LOAD;
            ST_LOAD:          w_state_next = ST_HOLD;
            ST_HOLD:          if (w_hold_last) w_state_next = w_last_slot ? ST_DONE : ST_FETCH_A;
            ST_RUN:           if (w_run_end) w_state_next = ST_DONE;
            default:          w_state_next = ST_IDLE;
        endcase
        if (abort) begin
            w_state_next = ST_IDLE;
        end
    end

    // Outputs are registered, so their next values follow the next state.
    always_comb begin
        w_idx_next = r_idx;
        w_entries  = r_entries;
        w_error    = r_error;
        if (w_accept) begin
            w_idx_next = '0;
            w_entries  = '0;
            w_error    = 1'b0;
        end else if (w_hold_done) begin
            w_idx_next = r_idx + IDX_W'(1);
            w_entries  = r_entries + MEM_AW'(1);
            if (w_last_slot) begin
                w_error = 1'b1;
            end
        end

        w_mem_rd_en   = (w_state_next == ST_FETCH_A) || (w_state_next == ST_FETCH_D);
        w_mem_rd_addr = '0;
        if (w_state_next == ST_FETCH_A) begin
            w_mem_rd_addr = {w_idx_next, 1'b0};
        end else if (w_state_next == ST_FETCH_D) begin
            w_mem_rd_addr = {w_idx_next, 1'b1};
        end

        w_cgra_rst = (w_state_next == ST_CRST);
        w_busy     = (w_state_next != ST_IDLE) && (w_state_next != ST_DONE);
        w_done     = (w_state_next == ST_DONE);
        w_strobe   = (w_state_next == ST_HOLD);
        w_cfg_addr = '0;
        w_cfg_data = '0;
        if (w_state_next == ST_HOLD) begin
            if (r_state == ST_LOAD) begin
                w_cfg_addr = r_addr_q;
                w_cfg_data = bus.mem_rd_data;
            end else begin
                w_cfg_addr = r_cfg_addr;
                w_cfg_data = r_cfg_data;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset_in) begin
            r_idx         <= '0;
            r_addr_q      <= '0;
            r_run_cycles  <= '0;
            r_run_cnt     <= '0;
            r_mem_rd_en   <= 1'b0;
            r_mem_rd_addr <= '0;
            r_cgra_rst    <= 1'b0;
            r_cfg_addr    <= '0;
            r_cfg_data    <= '0;
            r_strobe      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_error       <= 1'b0;
            r_entries     <= '0;
        end else begin
            r_idx         <= w_idx_next;
            r_mem_rd_en   <= w_mem_rd_en;
            r_mem_rd_addr <= w_mem_rd_addr;
            r_cgra_rst    <= w_cgra_rst;
            r_cfg_addr    <= w_cfg_addr;
            r_cfg_data    <= w_cfg_data;
            r_strobe      <= w_strobe;
            r_busy        <= w_busy;
            r_done        <= w_done;
            r_error       <= w_error;
            r_entries     <= w_entries;
            r_run_cnt     <= (r_state == ST_RUN) ? r_run_cnt + RUN_W'(1) : '0;
            if (r_state == ST_FETCH_D) begin
                r_addr_q <= bus.mem_rd_data;
            end
            if (w_accept) begin
                r_run_cycles <= run_cycles;
            end
        end
    end

    assign bus.mem_rd_en       = r_mem_rd_en;
    assign bus.mem_rd_addr     = r_mem_rd_addr;
    assign bus.cgra_reset_out  = r_cgra_rst;
    assign bus.config_addr_out = r_cfg_addr;
    assign bus.config_data_out = r_cfg_data;
    assign bus.config_strobe   = r_strobe;
    assign busy                = r_busy;
    assign done                = r_done;
    assign error               = r_error;
    assign entries_loaded      = r_entries;
endmodule

// File: tb/tb_cgra_config_sequencer.sv
// Bench for cgra_config_sequencer: directed and random config tables compared
// against a table-walking reference model at the transaction level.
module tb_cgra_config_sequencer;
    import cgra_cfg_pkg::*;

    localparam int MEM_AW     = 3;
    localparam int CFG_HOLD   = 2;
    localparam int RST_CYCLES = 4;
    localparam int SLOTS      = 1 << (MEM_AW - 1);
    localparam int BUDGET     = 400;
    localparam logic [31:0] SENT = 32'hFFFF_FFFF;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
    } pair_t;

    logic              clk_in = 1'b0;
    logic              reset_in, start, abort;
    logic [63:0]       run_cycles;
    logic              busy, done, error;
    logic [MEM_AW-1:0] entries_loaded;

    cgra_config_sequencer_if #(.MEM_AW(MEM_AW)) bus_if ();

    cgra_config_sequencer #(
        .MEM_AW     (MEM_AW),
        .CFG_HOLD   (CFG_HOLD),
        .RST_CYCLES (RST_CYCLES),
        .SENTINEL   (SENT)
    ) dut (
        .clk_in         (clk_in),
        .reset_in       (reset_in),
        .start          (start),
        .abort          (abort),
        .run_cycles     (run_cycles),
        .bus            (bus_if),
        .busy           (busy),
        .done           (done),
        .error          (error),
        .entries_loaded (entries_loaded)
    );

    always #5 clk_in = ~clk_in;

    logic [31:0] mem [0:(1<<MEM_AW)-1];

    always @(posedge clk_in) begin
        if (reset_in) bus_if.mem_rd_data <= '0;
        else if (bus_if.mem_rd_en) bus_if.mem_rd_data <= mem[bus_if.mem_rd_addr];
    end

    int    n_checks = 0;
    int    n_errors = 0;
    pair_t exp_pairs[$];
    int    exp_reads[$];
    bit    exp_err;
    int    exp_run;
    pair_t obs_pairs[$];
    int    obs_lens[$];
    int    obs_reads[$];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: walk the table slot by slot until a terminator or the last slot.
    task automatic build_model(input logic [63:0] rc);
        exp_pairs.delete();
        exp_reads.delete();
        exp_err = 1'b0;
        for (int i = 0; i < SLOTS; i++) begin
            exp_reads.push_back(2 * i);
            exp_reads.push_back(2 * i + 1);
            if (mem[2*i] == SENT) break;
            exp_pairs.push_back('{a: mem[2*i], d: mem[2*i+1]});
            if (i == SLOTS - 1) exp_err = 1'b1;
        end
        exp_run = exp_err ? 0 : ((rc == 64'd0) ? 1 : int'(rc));
    endtask

    task automatic fill_table(input int n_entries);
        for (int w = 0; w < (1 << MEM_AW); w++) begin
            mem[w] = $urandom;
            if ((w % 2 == 0) && (mem[w] == SENT)) mem[w] = 32'h0000_1234;
        end
        if (n_entries < SLOTS) mem[2*n_entries] = SENT;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_bus"}, {bus_if.config_addr_out, bus_if.config_data_out}, 64'd0);
        check_val({tag, "_ctl"}, 64'({busy, done, error, entries_loaded, bus_if.mem_rd_en,
                                      bus_if.mem_rd_addr, bus_if.cgra_reset_out,
                                      bus_if.config_strobe}), 64'd0);
    endtask

    // mode 0: plain run; 1: start pulsed during HOLD of entry 0;
    // 2: abort during HOLD of entry 0; 3: reset_in together with start during RUN.
    task automatic run_seq(input string name, input logic [63:0] rc, input int mode);
        int    cyc, rst_cnt, rst_first, rst_last, first_strobe;
        int    bus_bad, busy_bad, quiet, cur_len;
        bit    in_strobe, hit, post, finished;
        pair_t cur;
        build_model(rc);
        obs_pairs.delete();
        obs_lens.delete();
        obs_reads.delete();
        rst_cnt = 0; rst_first = -1; rst_last = -1; first_strobe = -1;
        bus_bad = 0; busy_bad = 0; quiet = 0; cur_len = 0; cur = '0;
        in_strobe = 0; hit = 0; post = 0; finished = 0;
        run_cycles = rc;
        start = 1'b1;
        @(negedge clk_in);
        start = 1'b0;
        cyc = 1;
        while (!finished && cyc < BUDGET) begin
            if (post) begin
                if (mode == 2) begin
                    check_val("abort_busy", 64'(busy), 64'd0);
                    check_val("abort_strobe", 64'(bus_if.config_strobe), 64'd0);
                    check_val("abort_bus", {bus_if.config_addr_out, bus_if.config_data_out}, 64'd0);
                    check_val("abort_rd_rst", 64'({bus_if.mem_rd_en, bus_if.cgra_reset_out}), 64'd0);
                    check_val("abort_kept", 64'({error, entries_loaded}), 64'd0);
                end else begin
                    check_all_zero("midrun_reset");
                end
                finished = 1;
            end else begin
                if (bus_if.cgra_reset_out) begin
                    rst_cnt++;
                    if (rst_first < 0) rst_first = cyc;
                    rst_last = cyc;
                end
                if (bus_if.mem_rd_en) obs_reads.push_back(int'(bus_if.mem_rd_addr));
                if (bus_if.config_strobe) begin
                    if (!in_strobe) begin
                        in_strobe = 1;
                        cur = '{a: bus_if.config_addr_out, d: bus_if.config_data_out};
                        cur_len = 0;
                        if (first_strobe < 0) first_strobe = cyc;
                    end else if ({bus_if.config_addr_out, bus_if.config_data_out} != cur) begin
                        bus_bad++;
                    end
                    cur_len++;
                end else begin
                    if (in_strobe) begin
                        obs_pairs.push_back(cur);
                        obs_lens.push_back(cur_len);
                        in_strobe = 0;
                    end
                    if ((bus_if.config_addr_out | bus_if.config_data_out) != 32'd0) bus_bad++;
                end
                if (bus_if.mem_rd_en || bus_if.config_strobe || bus_if.cgra_reset_out) quiet = 0;
                else if (busy) quiet++;
                if (done) begin
                    finished = 1;
                end else begin
                    if (!busy) busy_bad++;
                    if (!hit && mode == 1 && bus_if.config_strobe) begin
                        start = 1'b1; hit = 1;
                    end else if (!hit && mode == 2 && bus_if.config_strobe) begin
                        abort = 1'b1; hit = 1; post = 1;
                    end else if (!hit && mode == 3 && quiet == 3) begin
                        reset_in = 1'b1; start = 1'b1; hit = 1; post = 1;
                    end
                end
            end
            if (!finished) begin
                @(negedge clk_in);
                start = 1'b0; abort = 1'b0; reset_in = 1'b0;
                cyc++;
            end
        end
        check_val({name, "_finished"}, 64'(finished), 64'd1);
        if (mode < 2 && finished) begin
            check_val({name, "_busy_at_done"}, 64'(busy), 64'd0);
            check_val({name, "_busy_gaps"}, 64'(busy_bad), 64'd0);
            check_val({name, "_rst_len"}, 64'(rst_cnt), 64'(RST_CYCLES));
            check_val({name, "_rst_first"}, 64'(rst_first), 64'd1);
            check_val({name, "_n_reads"}, 64'(obs_reads.size()), 64'(exp_reads.size()));
            for (int k = 0; k < obs_reads.size() && k < exp_reads.size(); k++)
                check_val({name, "_rd_addr"}, 64'(obs_reads[k]), 64'(exp_reads[k]));
            check_val({name, "_n_pairs"}, 64'(obs_pairs.size()), 64'(exp_pairs.size()));
            for (int k = 0; k < obs_pairs.size() && k < exp_pairs.size(); k++) begin
                check_val({name, "_pair"}, obs_pairs[k], exp_pairs[k]);
                check_val({name, "_hold_len"}, 64'(obs_lens[k]), 64'(CFG_HOLD));
            end
            if (exp_pairs.size() > 0)
                check_val({name, "_first_strobe"}, 64'(first_strobe), 64'(rst_last + 4));
            check_val({name, "_bus_idle"}, 64'(bus_bad), 64'd0);
            check_val({name, "_run_len"}, 64'(quiet), 64'(exp_run));
            check_val({name, "_entries"}, 64'(entries_loaded), 64'(exp_pairs.size()));
            check_val({name, "_error"}, 64'(error), 64'(exp_err));
        end
        $display("run %-12s mode=%0d rc=%0d pairs=%0d/%0d err=%0d run=%0d/%0d cycles=%0d",
                 name, mode, rc, obs_pairs.size(), exp_pairs.size(), error, quiet, exp_run, cyc);
    endtask

    initial begin
        reset_in = 1'b1; start = 1'b0; abort = 1'b0; run_cycles = '0;
        for (int w = 0; w < (1 << MEM_AW); w++) mem[w] = '0;
        repeat (3) @(negedge clk_in);
        check_all_zero("reset_held");
        reset_in = 1'b0;
        @(negedge clk_in);
        check_all_zero("reset_idle");

        fill_table(1);
        mem[0] = 32'h0001_0002; mem[1] = 32'h0000_0003;
        run_seq("single", 64'd10, 0);

        fill_table(3);
        mem[0] = 32'h10; mem[1] = 32'hA0; mem[2] = 32'h20;
        mem[3] = 32'hB0; mem[4] = 32'h30; mem[5] = 32'hC0;
        run_seq("three", 64'd5, 0);
        run_seq("start_hold", 64'd5, 1);
        run_seq("abort_hold", 64'd5, 2);
        run_seq("restart", 64'd5, 0);

        fill_table(SLOTS);
        run_seq("overrun", 64'd7, 0);

        fill_table(1);
        run_seq("reset_run", 64'd10, 3);
        run_seq("zero_run", 64'd0, 0);

        for (int t = 0; t < 20; t++) begin
            fill_table(int'($urandom_range(0, SLOTS)));
            run_seq("random", 64'($urandom_range(0, 12)), 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
